// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin sharing of one UART byte transmitter among up to four
//   requesters. The winning byte is latched, a one-cycle start is issued, and
//   the transmitter busy flag is followed through a full frame before the
//   next grant. A sticky error flags a transmitter that never goes busy.
//
//   Optional feature: define UART_TX_ARB_LOCK_EN to let a requester holding
//   lock[i] keep the grant for back-to-back bytes without a round-robin step.
//   With the macro undefined the lock input is ignored.
//
// Handshake: req[i] is a level request and data[8i+7:8i] must be stable
//   while it is high. The arbiter accepts the byte with a one-cycle ack[i]
//   pulse, after which the requester drops req[i] or presents its next byte.
//   req is only looked at while the arbiter is idle, so a request raised
//   mid-frame simply waits. tx_start is a single-cycle pulse and tx_busy is
//   the transmitter's level frame-in-progress flag.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  input  logic [NREQ-1:0]   lock,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [1:0]        grant_id,
  output logic              busy,
  output logic              err,
  input  logic              err_clr,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [9:0]        cnt_q, cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic [1:0]        grant_q, grant_d;
  logic              err_q, err_d;
  logic              err_set;

  logic              rr_found;
  logic [1:0]        rr_win;
  logic [7:0]        rr_byte;
  logic [NREQ-1:0]   rr_ack;

  // Round-robin search starting one past the last granted index.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = ptr_q;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rr_found && req[i] && (((int'(ptr_q) + off) % NREQ) == i)) begin
          rr_found = 1'b1;
          rr_win   = 2'(i);
        end
      end
    end
  end

  // Byte and ack pattern belonging to the round-robin winner.
  always_comb begin
    rr_byte = 8'h00;
    rr_ack  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rr_win == 2'(i)) begin
        rr_byte   = data[8*i +: 8];
        rr_ack[i] = 1'b1;
      end
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic              lock_hold;
  logic [7:0]        lock_byte;
  logic [NREQ-1:0]   lock_ack;

  // Current holder keeps the grant when it still requests with lock set.
  always_comb begin
    lock_hold = 1'b0;
    lock_byte = 8'h00;
    lock_ack  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == 2'(i)) begin
        lock_hold   = lock[i] & req[i];
        lock_byte   = data[8*i +: 8];
        lock_ack[i] = 1'b1;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // Next-state and next-output logic for the grant/frame sequencer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    grant_d    = grant_q;
    err_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          ack_d     = rr_ack;
          tx_data_d = rr_byte;
          grant_d   = rr_win;
          ptr_d     = rr_win;
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_start_d = 1'b1;
        cnt_d      = 10'd0;
        state_d    = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q == TIMEOUT_C) begin
          // Byte is dropped; a lock cannot carry across this path.
          err_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
          if (lock_hold) begin
            ack_d     = lock_ack;
            tx_data_d = lock_byte;
            state_d   = S_START;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'(NREQ - 1);
      cnt_q      <= 10'd0;
      ack_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      grant_q    <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
    end
  end

  assign ack       = ack_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for the UART transmitter arbiter.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 1023;
  localparam int FRAME   = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  lock;
  logic [3:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;
  logic        err_clr;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] exp_ack;
    logic [1:0] exp_id;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs [13];
  logic [9:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data     (data),
    .lock     (lock),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr),
    .state_dbg(state_dbg)
  );

  // transmitter model: goes busy the cycle after a start, ignores starts while busy
  logic model_en = 1'b1;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (model_en && tx_start) busy_cnt <= FRAME;
  end
  assign tx_busy = (busy_cnt != 0);

  // protocol monitor: no start into a busy transmitter, at most one ack bit
  logic mon_en = 1'b1;
  int   viol = 0;
  always @(negedge clk) begin
    if (mon_en && rst_n && ((tx_start && tx_busy) || ($countones(ack) > 1)))
      viol <= viol + 1;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name, input int max);
    int n = 0;
    while (ack == 4'b0000 && n < max) begin
      tick();
      n++;
    end
    if (ack == 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL %s: no ack within %0d cycles", name, max);
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s: still busy after %0d cycles", name, max);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 4'b0000;
    lock    = 4'b0000;
    err_clr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic       early;
    logic       held_ok;
    logic [9:0] got;
    int         n0;
    int         n1;
    int         idle_gap;
    int         c;

    vecs[0]  = '{4'b1111, 4'b0001, 2'd0, 8'h10};
    vecs[1]  = '{4'b1111, 4'b0010, 2'd1, 8'h11};
    vecs[2]  = '{4'b1111, 4'b0100, 2'd2, 8'h12};
    vecs[3]  = '{4'b1111, 4'b1000, 2'd3, 8'h13};
    vecs[4]  = '{4'b1111, 4'b0001, 2'd0, 8'h10};
    vecs[5]  = '{4'b0101, 4'b0100, 2'd2, 8'h12};
    vecs[6]  = '{4'b0101, 4'b0001, 2'd0, 8'h10};
    vecs[7]  = '{4'b0010, 4'b0010, 2'd1, 8'h11};
    vecs[8]  = '{4'b1001, 4'b1000, 2'd3, 8'h13};
    vecs[9]  = '{4'b1001, 4'b0001, 2'd0, 8'h10};
    vecs[10] = '{4'b1000, 4'b1000, 2'd3, 8'h13};
    vecs[11] = '{4'b0110, 4'b0010, 2'd1, 8'h11};
    vecs[12] = '{4'b0110, 4'b0100, 2'd2, 8'h12};

    // reset values
    rst_n = 1'b1; req = 4'b0000; lock = 4'b0000; data = 32'h0; err_clr = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst_n = 1'b1;
    tick();

    // single request: exact latency and data hold through the frame
    data = 32'h0000_0041;
    req  = 4'b0001;
    tick();
    check("single_ack", 32'(ack), 32'h1);
    check("single_tx_data", 32'(tx_data), 32'h41);
    check("single_grant", 32'(grant_id), 32'h0);
    check("single_no_early_start", 32'(tx_start), 32'h0);
    check("single_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    check("single_ack_pulse", 32'(ack), 32'h0);
    check("single_tx_start", 32'(tx_start), 32'h1);
    tick();
    check("single_start_pulse", 32'(tx_start), 32'h0);
    held_ok = 1'b1;
    c = 0;
    while (busy && c < 40) begin
      if (tx_data !== 8'h41) held_ok = 1'b0;
      tick();
      c++;
    end
    check("single_data_held", 32'(held_ok), 32'h1);
    check("single_back_idle", 32'(busy), 32'h0);

    // round-robin vector table
    do_reset();
    data = 32'h1312_1110;
    for (int v = 0; v < 13; v++) begin
      req = vecs[v].req;
      wait_ack($sformatf("rr%0d_wait", v), 50);
      check($sformatf("rr%0d_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
      check($sformatf("rr%0d_grant", v), 32'(grant_id), 32'(vecs[v].exp_id));
      check($sformatf("rr%0d_data", v), 32'(tx_data), 32'(vecs[v].exp_byte));
      tick();
      check($sformatf("rr%0d_start", v), 32'(tx_start), 32'h1);
      wait_idle($sformatf("rr%0d_idle", v), 100);
    end
    req = 4'b0000;

    // request raised mid-frame waits and wins from ptr=0
    req = 4'b0001;
    wait_ack("mid_first_wait", 50);
    check("mid_first_grant", 32'(grant_id), 32'h0);
    c = 0;
    while (!tx_busy && c < 20) begin tick(); c++; end
    check("mid_tx_busy_seen", 32'(tx_busy), 32'h1);
    req = 4'b0011;
    wait_idle("mid_idle1", 100);
    wait_ack("mid_second_wait", 50);
    check("mid_second_ack", 32'(ack), 32'h2);
    check("mid_second_data", 32'(tx_data), 32'h11);
    req = 4'b0001;
    wait_idle("mid_idle2", 100);
    wait_ack("mid_third_wait", 50);
    check("mid_third_grant", 32'(grant_id), 32'h0);
    req = 4'b0000;
    wait_idle("mid_idle3", 100);

    // transmitter never goes busy: timeout
    model_en = 1'b0;
    req = 4'b0001;
    wait_ack("to_wait", 50);
    req = 4'b0000;
    tick();
    check("to_start", 32'(tx_start), 32'h1);
    early = 1'b0;
    repeat (TIMEOUT) begin
      tick();
      if (err) early = 1'b0 | 1'b1;
    end
    check("to_not_early", 32'(early), 32'h0);
    tick();
    check("to_err_set", 32'(err), 32'h1);
    check("to_back_idle", 32'(busy), 32'h0);
    check("to_state_idle", 32'(state_dbg), 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_clr", 32'(err), 32'h0);

    // set beats clear in the same cycle
    err_clr = 1'b1;
    req = 4'b0001;
    wait_ack("to2_wait", 50);
    req = 4'b0000;
    tick();
    repeat (TIMEOUT + 1) tick();
    check("to2_set_over_clr", 32'(err), 32'h1);
    err_clr = 1'b0;
    tick();
    check("to2_sticky", 32'(err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to2_cleared", 32'(err), 32'h0);
    model_en = 1'b1;

    // reset in the middle of a frame
    req = 4'b0100;
    wait_ack("mr_wait", 50);
    check("mr_grant", 32'(grant_id), 32'h2);
    check("mr_data", 32'(tx_data), 32'h12);
    c = 0;
    while (state_dbg != 2'd3 && c < 20) begin tick(); c++; end
    check("mr_in_wait_lo", 32'(state_dbg), 32'h3);
    mon_en = 1'b0;
    req = 4'b0001;
    rst_n = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_tx_data", 32'(tx_data), 32'h00);
    check("mr_ack", 32'(ack), 32'h0);
    check("mr_grant_rst", 32'(grant_id), 32'h0);
    tick();
    rst_n = 1'b1;
    wait_ack("mr_regrant_wait", 20);
    check("mr_regrant_ack", 32'(ack), 32'h1);
    check("mr_regrant_data", 32'(tx_data), 32'h10);
    req = 4'b0000;
    wait_idle("mr_idle", 100);
    c = 0;
    while (tx_busy && c < 20) begin tick(); c++; end
    mon_en = 1'b1;

    // requester 1 with lock streams three bytes while requester 0 sends two
    data = 32'h1312_2130;
`ifdef UART_TX_ARB_LOCK_EN
    exp_q.push_back({2'd1, 8'h21});
    exp_q.push_back({2'd1, 8'h22});
    exp_q.push_back({2'd1, 8'h23});
    exp_q.push_back({2'd0, 8'h30});
    exp_q.push_back({2'd0, 8'h31});
`else
    exp_q.push_back({2'd1, 8'h21});
    exp_q.push_back({2'd0, 8'h30});
    exp_q.push_back({2'd1, 8'h22});
    exp_q.push_back({2'd0, 8'h31});
    exp_q.push_back({2'd1, 8'h23});
`endif
    lock = 4'b0010;
    req  = 4'b0011;
    n0 = 0;
    n1 = 0;
    idle_gap = 0;
    c = 0;
    while (exp_q.size() != 0 && c < 600) begin
      tick();
      c++;
      if (n1 >= 1 && n1 < 3 && !busy) idle_gap++;
      if (ack != 4'b0000) begin
        got = {grant_id, tx_data};
        check("lock_seq", 32'(got), 32'(exp_q.pop_front()));
        if (ack[1]) begin
          n1++;
          data[15:8] = 8'h21 + 8'(n1);
          if (n1 == 3) begin req[1] = 1'b0; lock[1] = 1'b0; end
        end
        if (ack[0]) begin
          n0++;
          data[7:0] = 8'h30 + 8'(n0);
          if (n0 == 2) req[0] = 1'b0;
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL lock_seq_timeout: %0d grants missing", exp_q.size());
    end
`ifdef UART_TX_ARB_LOCK_EN
    check("lock_no_idle_gap", 32'(idle_gap), 32'h0);
`endif
    req  = 4'b0000;
    lock = 4'b0000;
    wait_idle("lock_idle", 100);

    check("protocol_monitor", 32'(viol), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
